// File: rtl/dma_request_scheduler.sv
// Round-robin scheduler for the shared-memory copy engine. Each processor raises a request
// by toggling its trigger line; the scheduler grants one requester at a time, latches its
// copy descriptor, starts the engine, and toggles the processor's ack once the copy is done.
module dma_request_scheduler #(
  parameter int unsigned PROC_CNT = 4,
  parameter int unsigned SIZE     = 16,
  parameter int unsigned PROCSIZE = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [PROC_CNT-1:0]          trigger,
  output logic [PROC_CNT-1:0]          ack,
  input  logic [PROC_CNT*SIZE-1:0]     ptr_flat,
  input  logic [PROC_CNT*PROCSIZE-1:0] copy_start_flat,
  input  logic [PROC_CNT*PROCSIZE-1:0] copy_length_flat,
  output logic                         eng_start,
  output logic [$clog2(PROC_CNT)-1:0]  eng_proc,
  output logic [SIZE-1:0]              eng_ptr,
  output logic [PROCSIZE-1:0]          eng_copy_start,
  output logic [PROCSIZE-1:0]          eng_copy_length,
  input  logic                         eng_done,
  output logic                         busy,
  output logic                         err_spurious
);

  localparam int unsigned PW  = $clog2(PROC_CNT);
  localparam int unsigned PW1 = PW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [PROC_CNT-1:0]   ack_q, ack_d;
  logic [PROC_CNT-1:0]   last_trigger_q, last_trigger_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  eng_start_q, eng_start_d;
  logic [PW-1:0]         eng_proc_q, eng_proc_d;
  logic [SIZE-1:0]       eng_ptr_q, eng_ptr_d;
  logic [PROCSIZE-1:0]   eng_copy_start_q, eng_copy_start_d;
  logic [PROCSIZE-1:0]   eng_copy_length_q, eng_copy_length_d;
  logic                  err_q, err_d;

  logic [PROC_CNT-1:0]   pending;
  logic                  any_pending;
  logic [PW-1:0]         winner;
  logic [SIZE-1:0]       ptr_arr      [PROC_CNT];
  logic [PROCSIZE-1:0]   start_arr    [PROC_CNT];
  logic [PROCSIZE-1:0]   length_arr   [PROC_CNT];

  // Unpack the flat per-processor descriptor buses.
  always_comb begin
    for (int i = 0; i < int'(PROC_CNT); i++) begin
      ptr_arr[i]    = ptr_flat[i*SIZE +: SIZE];
      start_arr[i]  = copy_start_flat[i*PROCSIZE +: PROCSIZE];
      length_arr[i] = copy_length_flat[i*PROCSIZE +: PROCSIZE];
    end
  end

  // Round-robin search starting at rr_ptr; the wrap is an explicit compare so that
  // non-power-of-two requester counts work.
  always_comb begin
    logic [PW1-1:0] cand;
    logic           found;
    pending     = trigger ^ last_trigger_q;
    any_pending = |pending;
    winner      = '0;
    found       = 1'b0;
    cand        = '0;
    for (int unsigned k = 0; k < PROC_CNT; k++) begin
      cand = {1'b0, rr_ptr_q} + PW1'(k);
      if (cand >= PW1'(PROC_CNT)) begin
        cand = cand - PW1'(PROC_CNT);
      end
      if (!found && pending[cand[PW-1:0]]) begin
        found  = 1'b1;
        winner = cand[PW-1:0];
      end
    end
  end

  // Next-state logic: grant in IDLE, wait for the engine in RUN, hand back the ack in DONE.
  always_comb begin
    state_d           = state_q;
    ack_d             = ack_q;
    last_trigger_d    = last_trigger_q;
    rr_ptr_d          = rr_ptr_q;
    eng_start_d       = 1'b0;
    eng_proc_d        = eng_proc_q;
    eng_ptr_d         = eng_ptr_q;
    eng_copy_start_d  = eng_copy_start_q;
    eng_copy_length_d = eng_copy_length_q;
    // A completion pulse outside RUN has no owner; flag it until reset.
    err_d             = err_q | (eng_done && (state_q != StRun));

    unique case (state_q)
      StIdle: begin
        if (any_pending) begin
          eng_proc_d        = winner;
          eng_ptr_d         = ptr_arr[winner];
          eng_copy_start_d  = start_arr[winner];
          eng_copy_length_d = length_arr[winner];
          if (length_arr[winner] != '0) begin
            eng_start_d = 1'b1;
            state_d     = StRun;
          end else begin
            // Zero-length copies never reach the engine.
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (eng_done) begin
          state_d = StDone;
        end
      end
      StDone: begin
        ack_d[eng_proc_q]          = ~ack_q[eng_proc_q];
        last_trigger_d[eng_proc_q] = ~last_trigger_q[eng_proc_q];
        if (32'(eng_proc_q) == PROC_CNT - 1) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = eng_proc_q + PW'(1);
        end
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous active-low reset; levels present during reset are
  // absorbed into last_trigger so they do not count as requests.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q           <= StIdle;
      ack_q             <= '0;
      last_trigger_q    <= trigger;
      rr_ptr_q          <= '0;
      eng_start_q       <= 1'b0;
      eng_proc_q        <= '0;
      eng_ptr_q         <= '0;
      eng_copy_start_q  <= '0;
      eng_copy_length_q <= '0;
      err_q             <= 1'b0;
    end else begin
      state_q           <= state_d;
      ack_q             <= ack_d;
      last_trigger_q    <= last_trigger_d;
      rr_ptr_q          <= rr_ptr_d;
      eng_start_q       <= eng_start_d;
      eng_proc_q        <= eng_proc_d;
      eng_ptr_q         <= eng_ptr_d;
      eng_copy_start_q  <= eng_copy_start_d;
      eng_copy_length_q <= eng_copy_length_d;
      err_q             <= err_d;
    end
  end

  assign ack             = ack_q;
  assign eng_start       = eng_start_q;
  assign eng_proc        = eng_proc_q;
  assign eng_ptr         = eng_ptr_q;
  assign eng_copy_start  = eng_copy_start_q;
  assign eng_copy_length = eng_copy_length_q;
  assign busy            = (state_q != StIdle);
  assign err_spurious    = err_q;

endmodule
